// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers producing data-domain divided waveforms.
// Each channel has a STOP/RUN/DRAIN controller, glitch-free half-period reload and a rising-edge counter.
module clk_div_bank #(
    parameter int NCH  = 2,
    parameter int DIVW = 8,
    parameter int CNTW = 32
) (
    input  logic                 fastclk,
    input  logic                 reset_l,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH*DIVW-1:0]  div,
    input  logic                 resync,
    input  logic [NCH-1:0]       cnt_clr,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH*CNTW-1:0]  count,
    output logic [NCH-1:0]       wrap
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ch_state_e;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        ch_state_e       state_q;
        logic [DIVW-1:0] ph_q;
        logic [DIVW-1:0] hs_q;
        logic            clk_q;
        logic            tick_q;
        logic [CNTW-1:0] cnt_q;
        logic [CNTW-1:0] cnt_d;
        logic            wrap_q;
        logic            wrap_d;
        logic [DIVW-1:0] div_ch;
        logic            at_toggle;

        assign div_ch    = div[gi*DIVW +: DIVW];
        assign at_toggle = (ph_q == hs_q);

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        always_ff @(posedge fastclk or negedge reset_l) begin
            if (!reset_l) begin
                state_q <= ST_STOP;
                ph_q    <= '0;
                hs_q    <= '0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else if (resync) begin
                ph_q   <= '0;
                hs_q   <= div_ch;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                if (state_q == ST_DRAIN) begin
                    state_q <= ST_STOP;
                end
            end else begin
                tick_q <= 1'b0;
                case (state_q)
                    ST_STOP: begin
                        ph_q  <= '0;
                        clk_q <= 1'b0;
                        if (enable[gi]) begin
                            state_q <= ST_RUN;
                            hs_q    <= div_ch;
                        end
                    end
                    ST_RUN, ST_DRAIN: begin
                        // Dropping enable during the low phase stops at once; during
                        // the high phase the pulse is allowed to finish (DRAIN).
                        if (!enable[gi] && !clk_q) begin
                            state_q <= ST_STOP;
                            ph_q    <= '0;
                        end else if (at_toggle) begin
                            clk_q   <= ~clk_q;
                            tick_q  <= ~clk_q;
                            ph_q    <= '0;
                            hs_q    <= div_ch;
                            state_q <= enable[gi] ? ST_RUN : ST_STOP;
                        end else begin
                            ph_q    <= ph_q + DIVW'(1);
                            state_q <= enable[gi] ? ST_RUN : ST_DRAIN;
                        end
                    end
                    default: begin
                        state_q <= ST_STOP;
                        ph_q    <= '0;
                        clk_q   <= 1'b0;
                    end
                endcase
            end
        end

        // NOTE: every variable written in always_comb gets a default first,
        // so no path can leave it unassigned and infer a latch.
        always_comb begin
            cnt_d  = cnt_q;
            wrap_d = wrap_q;
            if (cnt_clr[gi]) begin
                cnt_d  = '0;
                wrap_d = 1'b0;
            end else if (tick_q) begin
                cnt_d = cnt_q + CNTW'(1);
                if (&cnt_q) begin
                    wrap_d = 1'b1;
                end
            end
        end

        always_ff @(posedge fastclk or negedge reset_l) begin
            if (!reset_l) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                wrap_q <= wrap_d;
            end
        end

        assign clk_out[gi]               = clk_q;
        assign tick[gi]                  = tick_q;
        assign count[gi*CNTW +: CNTW]    = cnt_q;
        assign wrap[gi]                  = wrap_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed testbench for clk_div_bank: a 2-channel bank plus a 1-channel, 4-bit-counter
// instance for counter wrap and clear behaviour.
module tb_clk_div_bank;

    localparam int NCH  = 2;
    localparam int DIVW = 8;
    localparam int CNTW = 32;

    logic                fastclk = 1'b0;
    logic                reset_l;
    logic [NCH-1:0]      enable;
    logic [NCH*DIVW-1:0] div;
    logic                resync;
    logic [NCH-1:0]      cnt_clr;
    logic [NCH-1:0]      clk_out;
    logic [NCH-1:0]      tick;
    logic [NCH*CNTW-1:0] count;
    logic [NCH-1:0]      wrap;

    logic       w_enable;
    logic [7:0] w_div;
    logic       w_resync;
    logic       w_cnt_clr;
    logic       w_clk_out;
    logic       w_tick;
    logic [3:0] w_count;
    logic       w_wrap;

    int n_assert = 0;
    int n_fail   = 0;

    clk_div_bank #(.NCH(NCH), .DIVW(DIVW), .CNTW(CNTW)) u_dut (
        .fastclk (fastclk),
        .reset_l (reset_l),
        .enable  (enable),
        .div     (div),
        .resync  (resync),
        .cnt_clr (cnt_clr),
        .clk_out (clk_out),
        .tick    (tick),
        .count   (count),
        .wrap    (wrap)
    );

    clk_div_bank #(.NCH(1), .DIVW(8), .CNTW(4)) u_dut_w (
        .fastclk (fastclk),
        .reset_l (reset_l),
        .enable  (w_enable),
        .div     (w_div),
        .resync  (w_resync),
        .cnt_clr (w_cnt_clr),
        .clk_out (w_clk_out),
        .tick    (w_tick),
        .count   (w_count),
        .wrap    (w_wrap)
    );

    always #5 fastclk = ~fastclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge fastclk);
        #1;
    endtask

    // Channel 1 waveform for the div-change scenario: 4-cycle halves until the
    // falling toggle at cycle 88, 2-cycle halves afterwards.
    function automatic logic exp_clk1(input int k);
        if (k < 88) return ((k / 4) % 2) == 1;
        return (((k - 88) / 2) % 2) == 1;
    endfunction

    function automatic logic exp_tick1(input int k);
        if (k < 88) return (k % 8) == 4;
        return ((k - 88) % 4) == 2;
    endfunction

    initial begin
        reset_l   = 1'b0;
        enable    = '0;
        div       = '0;
        resync    = 1'b0;
        cnt_clr   = '0;
        w_enable  = 1'b0;
        w_div     = '0;
        w_resync  = 1'b0;
        w_cnt_clr = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        check("rst_clk_out", clk_out, 2'b00);
        check("rst_tick",    tick,    2'b00);
        check("rst_count",   count,   64'd0);
        check("rst_wrap",    wrap,    2'b00);
        check("rst_w_count", w_count, 4'd0);
        reset_l = 1'b1;

        // 4-bit counter wrap, then clear coincident with the 17th tick
        w_enable = 1'b1;
        next_cycle();
        for (int k = 1; k <= 36; k++) begin
            next_cycle();
            check("w_tick", w_tick, (k % 2) == 1);
            if (k == 30) begin
                check("w_count_15", w_count, 4'd15);
                check("w_wrap_0",   w_wrap,  1'b0);
            end
            if (k == 32) begin
                check("w_count_wrap", w_count, 4'd0);
                check("w_wrap_set",   w_wrap,  1'b1);
            end
            if (k == 33) begin
                check("w_wrap_sticky", w_wrap, 1'b1);
                w_cnt_clr = 1'b1;
            end
            if (k == 34) begin
                check("w_clr_count", w_count, 4'd0);
                check("w_clr_wrap",  w_wrap,  1'b0);
                w_cnt_clr = 1'b0;
            end
            if (k == 35) check("w_edge_dropped", w_count, 4'd0);
            if (k == 36) begin
                check("w_count_resume", w_count, 4'd1);
                check("w_wrap_clear",   w_wrap,  1'b0);
            end
        end
        w_enable = 1'b0;

        // Divide-by-2 and divide-by-8, then div1 3->1 during a high phase
        div    = {8'd3, 8'd0};
        enable = 2'b11;
        next_cycle();
        for (int k = 1; k <= 95; k++) begin
            next_cycle();
            check("ab_clk_out", clk_out, {exp_clk1(k), (k % 2) == 1});
            check("ab_tick",    tick,    {exp_tick1(k), (k % 2) == 1});
            if (k == 80) begin
                check("a_count0", count[31:0],  64'd40);
                check("a_count1", count[63:32], 64'd10);
            end
            if (k == 85) div[15:8] = 8'd1;
        end

        // Stop ch0, then drop enable right after a rise with div0=5
        enable[0] = 1'b0;
        repeat (3) next_cycle();
        check("c_stopped", clk_out[0], 1'b0);
        div[7:0]  = 8'd5;
        enable[0] = 1'b1;
        next_cycle();
        for (int j = 1; j <= 20; j++) begin
            next_cycle();
            check("c_clk0",  clk_out[0], (j >= 6) && (j <= 11));
            check("c_tick0", tick[0],    j == 6);
            if (j == 6) enable[0] = 1'b0;
        end

        // Resync with channels at different phases, equal div values afterwards
        div    = {8'd2, 8'd2};
        enable = 2'b11;
        repeat (4) next_cycle();
        resync = 1'b1;
        next_cycle();
        check("d_resync_clk",  clk_out, 2'b00);
        check("d_resync_tick", tick,    2'b00);
        resync = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            next_cycle();
            check("d_clk",  clk_out, {2{((j / 3) % 2) == 1}});
            check("d_tick", tick,    {2{(j % 6) == 3}});
        end
        check("d_wrap", wrap, 2'b00);

        // Asynchronous reset in the middle of a high phase
        repeat (3) next_cycle();
        check("e_high", clk_out, 2'b11);
        #3;
        reset_l = 1'b0;
        #1;
        check("e_async_clk",   clk_out, 2'b00);
        check("e_async_tick",  tick,    2'b00);
        check("e_async_count", count,   64'd0);
        check("e_async_wrap",  wrap,    2'b00);
        next_cycle();
        check("e_held_clk", clk_out, 2'b00);
        reset_l = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        check("e_restart_low", clk_out, 2'b00);
        next_cycle();
        check("e_restart_rise", clk_out, 2'b11);
        check("e_restart_tick", tick,    2'b11);
        next_cycle();
        check("e_restart_count", count, {32'd1, 32'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
